mem_access_unit: RTL and testbench

Load/store initiator for the MEM stage: accepts one memory request per handshake from the EX/MEM register and drives the word-addressed data memory's MemRead/MemWrite/address/write-data.

- Loads: selects the byte/halfword lane and sign- or zero-extends it.
- Sub-word stores (SB/SH): performed as a two-cycle read-modify-write, because the data memory writes whole words only.
- Backpressure: stalls the pipeline through `req_ready`.

---
 rtl/mem_access_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 119 +++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I width codes and FSM states.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends load data, and merges a sub-word store
// into an existing memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{addr_lo, 3'b000} +: 8];
  assign half_v = addr_lo[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_data = '0;
    merged    = word;
    case (funct3)
      F3_B: begin
        load_data = {{24{byte_v[7]}}, byte_v};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      F3_BU: load_data = {24'h0, byte_v};
      F3_H: begin
        load_data = {{16{half_v[15]}}, half_v};
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      F3_HU: load_data = {16'h0, half_v};
      F3_W: begin
        load_data = word;
        merged    = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with two-cycle read-modify-write for SB/SH.
// Define MEM_ACCESS_CHECK_EN to flag misaligned and out-of-range requests via rsp_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ALUresult,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  state_t      state, state_n;
  logic [31:0] merge_q, addr_q;
  logic [31:0] load_data, merged;
  logic        accept, illegal, flagged, blocked, err_cond, is_sub_store;

  mem_lane_align u_align (
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .word      (MemReadData),
    .wdata     (req_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready    = (state == IDLE);
  assign accept       = req_valid && req_ready;
  assign is_sub_store = req_write && (req_funct3 == F3_B || req_funct3 == F3_H);

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_write;
      default:          illegal = 1'b1;
    endcase
  end

`ifdef MEM_ACCESS_CHECK_EN
  always_comb begin
    flagged = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) flagged = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)               flagged = 1'b1;
  end
  assign err_cond = illegal || flagged;
`else
  assign flagged  = 1'b0;
  assign err_cond = 1'b0;
`endif

  assign blocked = illegal || flagged;

  // Enables are gated by rst so they fall in the same instant reset rises.
  always_comb begin
    state_n      = state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    ALUresult    = {req_addr[31:2], 2'b00};
    MemWriteData = req_wdata;
    case (state)
      IDLE: begin
        if (accept && !blocked && !rst) begin
          if (!req_write) begin
            MemRead = 1'b1;
          end else if (is_sub_store) begin
            MemRead = 1'b1;
            state_n = RMW_WR;
          end else begin
            MemWrite = 1'b1;
          end
        end
      end
      RMW_WR: begin
        MemWrite     = !rst;
        ALUresult    = addr_q;
        MemWriteData = merge_q;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      merge_q   <= '0;
      addr_q    <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= accept && (blocked || !req_write);
      rsp_err   <= accept && err_cond;
      if (accept && blocked)         rsp_data <= '0;
      else if (accept && !req_write) rsp_data <= load_data;
      if (accept && !blocked && is_sub_store) begin
        merge_q <= merged;
        addr_q  <= {req_addr[31:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven request vectors against a
// 32-word behavioural data memory, plus hand-written reset/idle/check-mode sequences.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        MemRead, MemWrite;
  logic [31:0] ALUresult, MemWriteData, MemReadData;

  logic [31:0] mem [0:31];
  logic        preload = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          overlap = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUresult(ALUresult),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  assign MemReadData = (ALUresult[31:2] < 30'd32) ? mem[ALUresult[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000_0015;
      mem[1] <= 32'd50;
      mem[2] <= 32'd18;
      mem[3] <= 32'h1122_3344;
      mem[7] <= 32'd100;
    end else if (MemWrite && ALUresult[31:2] < 30'd32) begin
      mem[ALUresult[6:2]] <= MemWriteData;
    end
  end

  always @(posedge clk or negedge clk)
    if (MemRead && MemWrite) overlap++;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit illegal_f(input vec_t v);
    if (v.f3 == 3'b011 || v.f3 == 3'b110 || v.f3 == 3'b111) return 1'b1;
    return v.wr && (v.f3 == 3'b100 || v.f3 == 3'b101);
  endfunction

  function automatic bit flag_f(input vec_t v);
    if (!CHK) return 1'b0;
    if ((v.f3 == 3'b001 || v.f3 == 3'b101) && v.addr[0]) return 1'b1;
    if (v.f3 == 3'b010 && v.addr[1:0] != 2'b00) return 1'b1;
    return v.addr[31:2] >= 30'd32;
  endfunction

  // Called and returns at a falling edge; issues one request and checks its effects.
  task automatic do_req(input vec_t v, input string nm);
    bit go, sub, sw;
    go  = !illegal_f(v) && !flag_f(v);
    sub = v.wr && (v.f3 == 3'b000 || v.f3 == 3'b001);
    sw  = v.wr && v.f3 == 3'b010;
    req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    #1;
    check({nm, ".ready"}, 32'(req_ready), 32'd1);
    check({nm, ".rd"}, 32'(MemRead), 32'(go && (!v.wr || sub)));
    check({nm, ".wr"}, 32'(MemWrite), 32'(go && sw));
    if (go) check({nm, ".addr"}, ALUresult, {v.addr[31:2], 2'b00});
    if (go && sw) check({nm, ".wd"}, MemWriteData, v.wdata);
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, ".rv"}, 32'(rsp_valid), 32'(v.rv));
    check({nm, ".err"}, 32'(rsp_err), 32'(v.rerr));
    if (v.rv) check({nm, ".data"}, rsp_data, v.rdata);
    if (go && sub) begin
      check({nm, ".rmw_ready"}, 32'(req_ready), 32'd0);
      check({nm, ".rmw_wr"}, 32'(MemWrite), 32'd1);
      check({nm, ".rmw_addr"}, ALUresult, {v.addr[31:2], 2'b00});
      @(negedge clk);
      check({nm, ".ready_back"}, 32'(req_ready), 32'd1);
    end
    check({nm, ".mem"}, mem[v.midx], v.mval);
  endtask

  vec_t vecs [19];
  vec_t cv;

  initial begin
    //          wr    f3      addr          wdata          rv    rdata          rerr  idx mval
    vecs[0]  = '{1'b0, 3'b010, 32'h04, 32'h0,          1'b1, 32'd50,        1'b0, 1, 32'd50};
    vecs[1]  = '{1'b1, 3'b000, 32'h01, 32'h0000_00FF,  1'b0, 32'h0,         1'b0, 0, 32'h0000_FF15};
    vecs[2]  = '{1'b0, 3'b000, 32'h01, 32'h0,          1'b1, 32'hFFFF_FFFF, 1'b0, 0, 32'h0000_FF15};
    vecs[3]  = '{1'b0, 3'b100, 32'h01, 32'h0,          1'b1, 32'h0000_00FF, 1'b0, 0, 32'h0000_FF15};
    vecs[4]  = '{1'b1, 3'b001, 32'h1E, 32'h0000_8001,  1'b0, 32'h0,         1'b0, 7, 32'h8001_0064};
    vecs[5]  = '{1'b0, 3'b001, 32'h1E, 32'h0,          1'b1, 32'hFFFF_8001, 1'b0, 7, 32'h8001_0064};
    vecs[6]  = '{1'b0, 3'b101, 32'h1E, 32'h0,          1'b1, 32'h0000_8001, 1'b0, 7, 32'h8001_0064};
    vecs[7]  = '{1'b1, 3'b010, 32'h18, 32'h1234_5678,  1'b0, 32'h0,         1'b0, 6, 32'h1234_5678};
    vecs[8]  = '{1'b0, 3'b010, 32'h18, 32'h0,          1'b1, 32'h1234_5678, 1'b0, 6, 32'h1234_5678};
    vecs[9]  = '{1'b0, 3'b000, 32'h00, 32'h0,          1'b1, 32'h0000_0015, 1'b0, 0, 32'h0000_FF15};
    vecs[10] = '{1'b0, 3'b001, 32'h00, 32'h0,          1'b1, 32'hFFFF_FF15, 1'b0, 0, 32'h0000_FF15};
    vecs[11] = '{1'b1, 3'b000, 32'h0E, 32'h0000_0077,  1'b0, 32'h0,         1'b0, 3, 32'h1177_3344};
    vecs[12] = '{1'b0, 3'b010, 32'h0C, 32'h0,          1'b1, 32'h1177_3344, 1'b0, 3, 32'h1177_3344};
    vecs[13] = '{1'b1, 3'b001, 32'h0C, 32'hCAFE_BEEF,  1'b0, 32'h0,         1'b0, 3, 32'h1177_BEEF};
    vecs[14] = '{1'b0, 3'b101, 32'h0E, 32'h0,          1'b1, 32'h0000_1177, 1'b0, 3, 32'h1177_BEEF};
    vecs[15] = '{1'b0, 3'b000, 32'h0D, 32'h0,          1'b1, 32'hFFFF_FFBE, 1'b0, 3, 32'h1177_BEEF};
    vecs[16] = '{1'b0, 3'b011, 32'h04, 32'h0,          1'b1, 32'h0,         CHK,  1, 32'd50};
    vecs[17] = '{1'b1, 3'b100, 32'h00, 32'h0000_DEAD,  1'b1, 32'h0,         CHK,  0, 32'h0000_FF15};
    vecs[18] = '{1'b1, 3'b111, 32'h04, 32'h0000_BEEF,  1'b1, 32'h0,         CHK,  1, 32'd50};

    repeat (2) @(negedge clk);
    preload = 1'b0;
    check("reset.rv", 32'(rsp_valid), 32'd0);
    check("reset.data", rsp_data, 32'h0);
    check("reset.err", 32'(rsp_err), 32'd0);
    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.en", {30'h0, MemRead, MemWrite}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    check("idle.en", {30'h0, MemRead, MemWrite}, 32'h0);
    check("idle.rv", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 19; i++) do_req(vecs[i], $sformatf("v%0d", i));

`ifdef MEM_ACCESS_CHECK_EN
    cv = '{1'b1, 3'b001, 32'h03, 32'h0000_AAAA, 1'b1, 32'h0, 1'b1, 0, 32'h0000_FF15};
    do_req(cv, "chk_sh_mis");
    check("chk_sh_mis.ready", 32'(req_ready), 32'd1);
    cv = '{1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 32'h0, 1'b1, 0, 32'h0000_FF15};
    do_req(cv, "chk_lw_range");
    cv = '{1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0, 1'b1, 1, 32'd50};
    do_req(cv, "chk_lw_mis");
`endif

    // Reset asserted while the RMW write is pending.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h08; req_wdata = 32'h0000_0055;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_rmw.pending_wr", 32'(MemWrite), 32'd1);
    check("rst_rmw.pending_ready", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_rmw.wr_drop", 32'(MemWrite), 32'd0);
    check("rst_rmw.rd_drop", 32'(MemRead), 32'd0);
    check("rst_rmw.idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rmw.mem2", mem[2], 32'd18);
    check("rst_rmw.rv", 32'(rsp_valid), 32'd0);

    cv = '{1'b0, 3'b010, 32'h08, 32'h0, 1'b1, 32'd18, 1'b0, 2, 32'd18};
    do_req(cv, "post_rst_lw");

    check("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
